// File: rtl/ghost_step_scheduler.sv
// Round scheduler for four ghosts: divides the clock into movement rounds, strobes
// each ghost one step in turn, then checks for collisions against pac-man.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

module ghost_step_scheduler #(
  parameter int TICK_DIV      = 5000000,
  parameter int FRIGHT_ROUNDS = 40
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [4*$clog2(`WIDTH)-1:0]   ghost_x,
  input  logic [4*$clog2(`HEIGHT)-1:0]  ghost_y,
  input  logic [$clog2(`WIDTH)-1:0]     pacman_x,
  input  logic [$clog2(`HEIGHT)-1:0]    pacman_y,
  input  logic                          pellet_eaten,
  output logic [3:0]                    step_strobe,
  output logic                          frightened,
  output logic [3:0]                    ghost_eaten,
  output logic                          pacman_caught,
  output logic                          round_done
);

  localparam int XW = $clog2(`WIDTH);
  localparam int YW = $clog2(`HEIGHT);
  localparam int TW = $clog2(TICK_DIV);
  localparam int FW = $clog2(FRIGHT_ROUNDS + 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FRIGHT_LOAD = FW'(FRIGHT_ROUNDS);

  typedef enum logic [2:0] {
    IDLE, COUNT, STEP0, STEP1, STEP2, STEP3, CHECK
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_count;
  logic [FW-1:0] fright_count;
  logic          abort_pending;
  logic [3:0]    match;

  for (genvar gi = 0; gi < 4; gi++) begin : g_match
    assign match[gi] = (ghost_x[gi*XW +: XW] == pacman_x) &&
                       (ghost_y[gi*YW +: YW] == pacman_y);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tick_count    <= '0;
      fright_count  <= '0;
      abort_pending <= 1'b0;
      step_strobe   <= '0;
      frightened    <= 1'b0;
      ghost_eaten   <= '0;
      pacman_caught <= 1'b0;
      round_done    <= 1'b0;
    end else begin
      step_strobe   <= '0;
      ghost_eaten   <= '0;
      pacman_caught <= 1'b0;
      round_done    <= 1'b0;

      // A pellet reload wins over the end-of-round decrement.
      if (pellet_eaten) begin
        fright_count <= FRIGHT_LOAD;
        frightened   <= (FRIGHT_LOAD != '0);
      end else if (state == CHECK && fright_count != '0) begin
        fright_count <= fright_count - FW'(1);
        frightened   <= (fright_count != FW'(1));
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state      <= COUNT;
            tick_count <= '0;
          end
        end
        COUNT: begin
          if (!enable) begin
            state      <= IDLE;
            tick_count <= '0;
          end else if (tick_count == TICK_LAST) begin
            state       <= STEP0;
            tick_count  <= '0;
            step_strobe <= 4'b0001;
          end else begin
            tick_count <= tick_count + TW'(1);
          end
        end
        STEP0: begin
          state       <= STEP1;
          step_strobe <= 4'b0010;
          if (!enable) abort_pending <= 1'b1;
        end
        STEP1: begin
          state       <= STEP2;
          step_strobe <= 4'b0100;
          if (!enable) abort_pending <= 1'b1;
        end
        STEP2: begin
          state       <= STEP3;
          step_strobe <= 4'b1000;
          if (!enable) abort_pending <= 1'b1;
        end
        STEP3: begin
          // Pausing mid-round still finishes all four steps, but skips the check.
          abort_pending <= 1'b0;
          if (abort_pending || !enable) state <= IDLE;
          else                          state <= CHECK;
        end
        CHECK: begin
          tick_count <= '0;
          if (!enable) begin
            state <= IDLE;
          end else begin
            state      <= COUNT;
            round_done <= 1'b1;
            if (|match) begin
              if (frightened) ghost_eaten   <= match;
              else            pacman_caught <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_step_scheduler.sv
// Directed bench for ghost_step_scheduler with TICK_DIV=4 and FRIGHT_ROUNDS=3;
// cycle numbers count rising edges after reset release with enable raised.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

module tb_ghost_step_scheduler;
  localparam int TICK_DIV      = 4;
  localparam int FRIGHT_ROUNDS = 3;
  localparam int XW = $clog2(`WIDTH);
  localparam int YW = $clog2(`HEIGHT);

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [4*XW-1:0] ghost_x;
  logic [4*YW-1:0] ghost_y;
  logic [XW-1:0]   pacman_x;
  logic [YW-1:0]   pacman_y;
  logic            pellet_eaten;
  logic [3:0]      step_strobe;
  logic            frightened;
  logic [3:0]      ghost_eaten;
  logic            pacman_caught;
  logic            round_done;

  int checks = 0;
  int fails  = 0;

  ghost_step_scheduler #(.TICK_DIV(TICK_DIV), .FRIGHT_ROUNDS(FRIGHT_ROUNDS)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ghost_x(ghost_x), .ghost_y(ghost_y),
    .pacman_x(pacman_x), .pacman_y(pacman_y),
    .pellet_eaten(pellet_eaten),
    .step_strobe(step_strobe), .frightened(frightened),
    .ghost_eaten(ghost_eaten), .pacman_caught(pacman_caught),
    .round_done(round_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic place_ghost(input int i, input int x, input int y);
    ghost_x[i*XW +: XW] = XW'(x);
    ghost_y[i*YW +: YW] = YW'(y);
  endtask

  task automatic scatter_ghosts();
    for (int i = 0; i < 4; i++) place_ghost(i, i + 1, i + 1);
    pacman_x = XW'(300);
    pacman_y = YW'(300);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; pellet_eaten = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic pulse_pellet();
    pellet_eaten = 1'b1;
    tick();
    pellet_eaten = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; pellet_eaten = 1'b0;
    scatter_ghosts();
    repeat (2) tick();
    checks++; if (step_strobe !== 4'b0000) begin fails++; $display("FAIL reset_strobe: got %b expected 0000", step_strobe); end
    checks++; if (frightened !== 1'b0) begin fails++; $display("FAIL reset_frightened: got %b expected 0", frightened); end
    checks++; if (ghost_eaten !== 4'b0000) begin fails++; $display("FAIL reset_ghost_eaten: got %b expected 0000", ghost_eaten); end
    checks++; if (pacman_caught !== 1'b0) begin fails++; $display("FAIL reset_caught: got %b expected 0", pacman_caught); end
    checks++; if (round_done !== 1'b0) begin fails++; $display("FAIL reset_round_done: got %b expected 0", round_done); end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_round_timing();
    logic [3:0] exp_s;
    logic       exp_r;
    do_reset();
    scatter_ghosts();
    enable = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k >= 5 && k <= 8) exp_s = 4'(1 << (k - 5));
      else if (k == 14)     exp_s = 4'b0001;
      else                  exp_s = 4'b0000;
      exp_r = (k == 10);
      checks++; if (step_strobe !== exp_s) begin fails++; $display("FAIL round_strobe cycle %0d: got %b expected %b", k, step_strobe, exp_s); end
      checks++; if (round_done !== exp_r) begin fails++; $display("FAIL round_done cycle %0d: got %b expected %b", k, round_done, exp_r); end
      if (k == 10) begin
        checks++; if (pacman_caught !== 1'b0) begin fails++; $display("FAIL round_no_catch: got %b expected 0", pacman_caught); end
      end
    end
    $display("test_round_timing done");
  endtask

  task automatic test_caught();
    do_reset();
    scatter_ghosts();
    place_ghost(2, 200, 240);
    pacman_x = XW'(200);
    pacman_y = YW'(240);
    enable = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 9) begin
        checks++; if (pacman_caught !== 1'b0) begin fails++; $display("FAIL caught_early: got %b expected 0", pacman_caught); end
      end
      if (k == 10) begin
        checks++; if (pacman_caught !== 1'b1) begin fails++; $display("FAIL caught_pulse: got %b expected 1", pacman_caught); end
        checks++; if (ghost_eaten !== 4'b0000) begin fails++; $display("FAIL caught_ghost_eaten: got %b expected 0000", ghost_eaten); end
      end
      if (k == 11) begin
        checks++; if (pacman_caught !== 1'b0) begin fails++; $display("FAIL caught_single: got %b expected 0", pacman_caught); end
      end
    end
    $display("test_caught done");
  endtask

  task automatic test_fright();
    do_reset();
    scatter_ghosts();
    pacman_x = XW'(50);
    pacman_y = YW'(60);
    place_ghost(0, 50, 60);
    place_ghost(3, 50, 60);
    pulse_pellet();
    checks++; if (frightened !== 1'b1) begin fails++; $display("FAIL fright_start: got %b expected 1", frightened); end
    enable = 1'b1;
    for (int k = 1; k <= 37; k++) begin
      tick();
      if (k == 10 || k == 19 || k == 28) begin
        checks++; if (ghost_eaten !== 4'b1001) begin fails++; $display("FAIL fright_eaten cycle %0d: got %b expected 1001", k, ghost_eaten); end
        checks++; if (pacman_caught !== 1'b0) begin fails++; $display("FAIL fright_no_catch cycle %0d: got %b expected 0", k, pacman_caught); end
      end
      if (k == 27) begin
        checks++; if (frightened !== 1'b1) begin fails++; $display("FAIL fright_hold: got %b expected 1", frightened); end
      end
      if (k == 28) begin
        checks++; if (frightened !== 1'b0) begin fails++; $display("FAIL fright_drop: got %b expected 0", frightened); end
      end
      if (k == 37) begin
        checks++; if (pacman_caught !== 1'b1) begin fails++; $display("FAIL fright_over_catch: got %b expected 1", pacman_caught); end
        checks++; if (ghost_eaten !== 4'b0000) begin fails++; $display("FAIL fright_over_eaten: got %b expected 0000", ghost_eaten); end
      end
    end
    $display("test_fright done");
  endtask

  task automatic test_pellet_coincide();
    do_reset();
    scatter_ghosts();
    pulse_pellet();
    enable = 1'b1;
    for (int k = 1; k <= 37; k++) begin
      tick();
      if (k == 9) pellet_eaten = 1'b1;
      if (k == 10) begin
        pellet_eaten = 1'b0;
        checks++; if (frightened !== 1'b1) begin fails++; $display("FAIL coincide_after: got %b expected 1", frightened); end
      end
      if (k == 28 || k == 36) begin
        checks++; if (frightened !== 1'b1) begin fails++; $display("FAIL coincide_hold cycle %0d: got %b expected 1", k, frightened); end
      end
      if (k == 37) begin
        checks++; if (frightened !== 1'b0) begin fails++; $display("FAIL coincide_drop: got %b expected 0", frightened); end
      end
    end
    $display("test_pellet_coincide done");
  endtask

  task automatic test_enable_drop();
    logic [3:0] exp_s;
    do_reset();
    scatter_ghosts();
    enable = 1'b1;
    repeat (6) tick();
    checks++; if (step_strobe !== 4'b0010) begin fails++; $display("FAIL drop_step1: got %b expected 0010", step_strobe); end
    enable = 1'b0;
    for (int k = 7; k <= 14; k++) begin
      tick();
      if (k == 7)      exp_s = 4'b0100;
      else if (k == 8) exp_s = 4'b1000;
      else             exp_s = 4'b0000;
      checks++; if (step_strobe !== exp_s) begin fails++; $display("FAIL drop_strobe cycle %0d: got %b expected %b", k, step_strobe, exp_s); end
      checks++; if (round_done !== 1'b0) begin fails++; $display("FAIL drop_round_done cycle %0d: got %b expected 0", k, round_done); end
    end
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_s = (k == 5) ? 4'b0001 : 4'b0000;
      checks++; if (step_strobe !== exp_s) begin fails++; $display("FAIL drop_restart cycle %0d: got %b expected %b", k, step_strobe, exp_s); end
    end
    $display("test_enable_drop done");
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_s;
    do_reset();
    scatter_ghosts();
    pulse_pellet();
    enable = 1'b1;
    repeat (7) tick();
    checks++; if (step_strobe !== 4'b0100) begin fails++; $display("FAIL mid_step2: got %b expected 0100", step_strobe); end
    #2 reset = 1'b1;
    #1;
    checks++; if (step_strobe !== 4'b0000) begin fails++; $display("FAIL mid_async_strobe: got %b expected 0000", step_strobe); end
    checks++; if (frightened !== 1'b0) begin fails++; $display("FAIL mid_async_fright: got %b expected 0", frightened); end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_s = (k == 5) ? 4'b0001 : 4'b0000;
      checks++; if (step_strobe !== exp_s) begin fails++; $display("FAIL mid_restart cycle %0d: got %b expected %b", k, step_strobe, exp_s); end
    end
    checks++; if (frightened !== 1'b0) begin fails++; $display("FAIL mid_fright_cleared: got %b expected 0", frightened); end
    $display("test_reset_mid done");
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    pellet_eaten = 1'b0;
    test_reset();
    test_round_timing();
    test_caught();
    test_fright();
    test_pellet_coincide();
    test_enable_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ghost_step_scheduler.md
GHOST_STEP_SCHEDULER -- requirements
Module: ghost_step_scheduler

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 5000000, meaning clock cycles per movement round (minimum 2).
REQ-002 SHALL provide parameter FRIGHT_ROUNDS, default 40, meaning movement rounds that frightened mode lasts after a power pellet.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: game running; 0 pauses ghost movement.
REQ-006 SHALL have port ghost_x, input, 4*$clog2(`WIDTH) bits: packed current ghost X positions; ghost i occupies slice i.
REQ-007 SHALL have port ghost_y, input, 4*$clog2(`HEIGHT) bits: packed current ghost Y positions; ghost i occupies slice i.
REQ-008 SHALL have port pacman_x, input, $clog2(`WIDTH) bits: pac-man X position.
REQ-009 SHALL have port pacman_y, input, $clog2(`HEIGHT) bits: pac-man Y position.
REQ-010 SHALL have port pellet_eaten, input, 1 bit: one-cycle pulse when pac-man eats a power pellet.
REQ-011 SHALL have port step_strobe, output, 4 bits: one-hot clock-enable pulse telling ghost i to advance one step.
REQ-012 SHALL have port frightened, output, 1 bit: high while frightened mode is active.
REQ-013 SHALL have port ghost_eaten, output, 4 bits: one-cycle pulse per ghost caught while frightened (respawn request).
REQ-014 SHALL have port pacman_caught, output, 1 bit: one-cycle pulse when a non-frightened ghost reaches pac-man.
REQ-015 SHALL have port round_done, output, 1 bit: one-cycle pulse at the end of each movement round.

Function
REQ-016 SHALL implement the states IDLE, COUNT, STEP0, STEP1, STEP2, STEP3 and CHECK.
REQ-017 SHALL go from IDLE to COUNT, with the tick counter at 0, on the first cycle enable=1.
REQ-018 SHALL, in COUNT, increment the tick counter each cycle and go to STEP0 in the cycle after it reaches TICK_DIV-1, clearing it.
REQ-019 SHALL step STEPi to STEP(i+1) every cycle; STEP3 goes to CHECK.
REQ-020 SHALL hold step_strobe[i]=1 only during STEPi, so exactly one bit is high per cycle, ghosts sequenced 0,1,2,3, one cycle each.
REQ-021 SHALL, in CHECK, compare every ghost slice against (pacman_x, pacman_y) for exact equality on both coordinates; positions reflect STEP3 updates.
REQ-022 SHALL, on a CHECK match while frightened=1, pulse ghost_eaten[i] for each matching ghost in the cycle after CHECK; multiple bits may be set.
REQ-023 SHALL, on a CHECK match while frightened=0, pulse pacman_caught for one cycle and leave ghost_eaten at 0.
REQ-024 SHALL pulse round_done in the cycle after CHECK, with CHECK returning to COUNT.
REQ-025 SHALL reload the fright counter with FRIGHT_ROUNDS on pellet_eaten=1 in any state, including IDLE.
REQ-026 SHALL decrement a nonzero fright counter once per CHECK.
REQ-027 SHALL drive frightened=1 exactly when the fright counter is nonzero.
REQ-028 SHALL, when pellet_eaten and a CHECK decrement coincide, perform the reload and not the decrement.
REQ-029 SHALL give a CHECK coinciding with a pellet reload the old frightened value when judging collisions.
REQ-030 SHALL, when enable=0 in COUNT or CHECK, go to IDLE next cycle and clear the tick counter, with no collision pulses.
REQ-031 SHALL, when enable=0 in STEPi, complete STEP3 and then go to IDLE, skipping CHECK, so a round never leaves ghosts half-stepped.
REQ-032 SHALL hold the fright counter while in IDLE.
REQ-033 SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-034 SHALL size the tick counter to $clog2(TICK_DIV) bits and never let it wrap past TICK_DIV-1.
REQ-035 SHALL size the fright counter to $clog2(FRIGHT_ROUNDS+1) bits with saturation at 0.

Reset
REQ-036 SHALL, on reset=1 asynchronously, force state IDLE, tick counter 0 and fright counter 0.
REQ-037 SHALL, on reset=1, force step_strobe=0, frightened=0, ghost_eaten=0, pacman_caught=0 and round_done=0.
REQ-038 SHALL, on reset=1 mid-round including STEPi, abort immediately with no further strobes.
REQ-039 SHALL resume from IDLE after reset is released.

Verification
REQ-040 SHALL cover: TICK_DIV=4, enable held 1 -> step_strobe 0001,0010,0100,1000 on consecutive cycles, then round_done, period 4+4+1 cycles.
REQ-041 SHALL cover: ghost2 at (200,240), pacman at (200,240), frightened=0 -> pacman_caught single pulse after CHECK, ghost_eaten=0000.
REQ-042 SHALL cover: pellet_eaten pulse, FRIGHT_ROUNDS=3, ghosts 0 and 3 on pac-man -> ghost_eaten=1001 in round 1, frightened drops after 3rd CHECK.
REQ-043 SHALL cover: pellet_eaten in the same cycle as a CHECK decrement -> counter equals FRIGHT_ROUNDS afterwards.
REQ-044 SHALL cover: enable drops during STEP1 -> STEP2 and STEP3 strobes still issue, no round_done, state IDLE.
REQ-045 SHALL cover: reset asserted during STEP2 -> step_strobe=0000 without a clock edge, frightened=0, restart from IDLE.
